// File: rtl/mem_pkg.sv
// Shared types and defaults for the I/D cache refill arbiter.
package mem_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int LINE_W_DEF = 64;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_WB    = 3'd1,
    D_FILL  = 3'd2,
    D_WRITE = 3'd3,
    I_FILL  = 3'd4,
    I_WRITE = 3'd5
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter
  import mem_pkg::*;
#(
  parameter int              W       = CNT_W,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I- and D-cache line refills (with dirty write-back) onto one
// unified memory port; D requests win over I requests.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no transaction; evaluate misses (D before I)
// D_WB    | write dirty victim line back, wait for u_rdy
// D_FILL  | read D miss line, wait for u_rdy, capture data
// D_WRITE | one-cycle d_fill_we pulse
// I_FILL  | read I miss line, wait for u_rdy, capture data
// I_WRITE | one-cycle i_fill_we pulse
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter int               LINE_W   = LINE_W_DEF,
  parameter logic [CNT_W-1:0] CNT_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_evict_addr,
  input  logic [LINE_W-1:0] d_evict_data,
  input  logic [LINE_W-1:0] u_rdata,
  input  logic              u_rdy,
  output logic              u_re,
  output logic              u_we,
  output logic [ADDR_W-1:0] u_addr,
  output logic [LINE_W-1:0] u_wdata,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [LINE_W-1:0] fill_data,
  output logic              stall,
  output logic [CNT_W-1:0]  i_miss_cnt,
  output logic [CNT_W-1:0]  d_miss_cnt
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [LINE_W-1:0] wb_data_q;
  logic [LINE_W-1:0] fill_data_q;
  logic              capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    u_re      = 1'b0;
    u_we      = 1'b0;
    u_addr    = '0;
    u_wdata   = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_miss && d_dirty) begin
          state_d = D_WB;
        end else if (d_miss) begin
          state_d = D_FILL;
        end else if (i_miss) begin
          state_d = I_FILL;
        end
      end
      D_WB: begin
        u_we    = 1'b1;
        u_addr  = wb_addr_q;
        u_wdata = wb_data_q;
        if (u_rdy) begin
          state_d = D_FILL;
        end
      end
      D_FILL: begin
        u_re   = 1'b1;
        u_addr = miss_addr_q;
        if (u_rdy) begin
          capture = 1'b1;
          state_d = D_WRITE;
        end
      end
      D_WRITE: begin
        d_fill_we = 1'b1;
        state_d   = IDLE;
      end
      I_FILL: begin
        u_re   = 1'b1;
        u_addr = miss_addr_q;
        if (u_rdy) begin
          capture = 1'b1;
          state_d = I_WRITE;
        end
      end
      I_WRITE: begin
        i_fill_we = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request info is frozen at IDLE exit so later input changes cannot
  // disturb the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (d_miss) begin
          miss_addr_q <= d_miss_addr;
          wb_addr_q   <= d_evict_addr;
          wb_data_q   <= d_evict_data;
        end else if (i_miss) begin
          miss_addr_q <= i_miss_addr;
        end
      end
      if (capture) begin
        fill_data_q <= u_rdata;
      end
    end
  end

  assign fill_data = fill_data_q;
  assign stall     = (state_q != IDLE) | i_miss | d_miss;

  sat_counter #(.W(CNT_W), .RST_VAL(CNT_INIT)) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (i_fill_we),
    .cnt   (i_miss_cnt)
  );

  sat_counter #(.W(CNT_W), .RST_VAL(CNT_INIT)) u_d_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (d_fill_we),
    .cnt   (d_miss_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder, bus monitor, and
// hand-computed expectations per scenario.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_miss, d_miss, d_dirty;
  logic [13:0] i_miss_addr, d_miss_addr, d_evict_addr;
  logic [63:0] d_evict_data;
  logic [63:0] rdata_val;
  logic        mem_rdy, force_rdy;
  logic        u_re, u_we, i_fill_we, d_fill_we, stall;
  logic [13:0] u_addr;
  logic [63:0] u_wdata, fill_data;
  logic [15:0] i_miss_cnt, d_miss_cnt;

  logic        i_miss2;
  logic        s_u_re, s_u_we, s_i_fill_we, s_d_fill_we, s_stall;
  logic [13:0] s_u_addr;
  logic [63:0] s_u_wdata, s_fill_data;
  logic [15:0] s_i_cnt, s_d_cnt;

  wire [63:0] u_rdata = rdata_val;
  wire        u_rdy   = mem_rdy | force_rdy;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_dirty(d_dirty), .d_evict_addr(d_evict_addr), .d_evict_data(d_evict_data),
    .u_rdata(u_rdata), .u_rdy(u_rdy),
    .u_re(u_re), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_data(fill_data),
    .stall(stall), .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
  );

  // Counter preset near saturation; memory always ready.
  mem_arbiter #(.CNT_INIT(16'hFFFE)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss2), .i_miss_addr(14'h0007),
    .d_miss(1'b0), .d_miss_addr(14'h0000),
    .d_dirty(1'b0), .d_evict_addr(14'h0000), .d_evict_data(64'h0),
    .u_rdata(64'h0123_4567_89AB_CDEF), .u_rdy(1'b1),
    .u_re(s_u_re), .u_we(s_u_we), .u_addr(s_u_addr), .u_wdata(s_u_wdata),
    .i_fill_we(s_i_fill_we), .d_fill_we(s_d_fill_we), .fill_data(s_fill_data),
    .stall(s_stall), .i_miss_cnt(s_i_cnt), .d_miss_cnt(s_d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  int          lat = 4;
  logic [13:0] exp_re_addr, exp_we_addr;

  int          cyc = 0, mcnt = 0;
  int          re_cyc = 0, we_cyc = 0, overlap = 0;
  int          re_addr_err = 0, we_addr_err = 0;
  int          dfill_n = 0, ifill_n = 0;
  int          last_dfill_cyc = 0, last_ifill_cyc = 0, gap = -1;
  logic        gap_pend = 1'b0;
  logic [63:0] dfill_data = '0, ifill_data = '0;
  logic [13:0] wr_addr = '0;
  logic [63:0] wr_data = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and memory responder; u_rdy rises after lat strobe cycles.
  always @(negedge clk) begin
    cyc++;
    if (u_re) re_cyc++;
    if (u_we) we_cyc++;
    if (u_re && u_we) overlap++;
    if (u_re && u_addr != exp_re_addr) re_addr_err++;
    if (u_we && u_addr != exp_we_addr) we_addr_err++;
    if (d_fill_we) begin
      dfill_n++;
      dfill_data = fill_data;
      last_dfill_cyc = cyc;
      gap_pend = 1'b1;
    end else if (gap_pend && u_re) begin
      gap = cyc - last_dfill_cyc;
      gap_pend = 1'b0;
    end
    if (i_fill_we) begin
      ifill_n++;
      ifill_data = fill_data;
      last_ifill_cyc = cyc;
    end
    if (mem_rdy) begin
      mem_rdy = 1'b0;
      mcnt = 0;
    end else if (u_re || u_we) begin
      mcnt++;
      if (mcnt >= lat) begin
        mem_rdy = 1'b1;
        if (u_we) begin
          wr_addr = u_addr;
          wr_data = u_wdata;
        end
      end
    end else begin
      mcnt = 0;
    end
  end

  // Caches drop their miss once the fill pulse is seen.
  task automatic run_until_idle(input int max_cyc);
    logic done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (d_fill_we) d_miss = 1'b0;
      if (i_fill_we) i_miss = 1'b0;
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    check_val("idle_timeout", done, 1'b1);
  endtask

  int b_re, b_we, b_df, b_if, b_ov, b_rae, b_wae, n;

  task automatic snap();
    b_re = re_cyc; b_we = we_cyc; b_df = dfill_n; b_if = ifill_n;
    b_ov = overlap; b_rae = re_addr_err; b_wae = we_addr_err;
  endtask

  initial begin
    rst_n = 1'b0;
    i_miss = 0; d_miss = 0; d_dirty = 0; i_miss2 = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_evict_addr = '0; d_evict_data = '0;
    rdata_val = '0; mem_rdy = 0; force_rdy = 0;
    exp_re_addr = '0; exp_we_addr = '0;
    #23;
    check_val("rst_u_re", u_re, 1'b0);
    check_val("rst_u_we", u_we, 1'b0);
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_fill_data", fill_data, 64'h0);
    check_val("rst_i_cnt", i_miss_cnt, 16'h0);
    check_val("rst_d_cnt", d_miss_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean D miss, 4-cycle latency
    snap();
    lat = 4; rdata_val = 64'hA5A5_0001_0002_0003; exp_re_addr = 14'h0010;
    d_miss_addr = 14'h0010; d_dirty = 0; d_miss = 1;
    #1 check_val("clean_stall_comb", stall, 1'b1);
    run_until_idle(40);
    check_val("clean_re_cycles", re_cyc - b_re, 4);
    check_val("clean_re_addr", re_addr_err - b_rae, 0);
    check_val("clean_no_we", we_cyc - b_we, 0);
    check_val("clean_dfill_pulses", dfill_n - b_df, 1);
    check_val("clean_dfill_data", dfill_data, 64'hA5A5_0001_0002_0003);
    check_val("clean_d_cnt", d_miss_cnt, 16'd1);
    repeat (3) @(negedge clk);
    check_val("clean_fill_hold", fill_data, 64'hA5A5_0001_0002_0003);

    // Dirty D miss: write-back then refill
    snap();
    lat = 4; rdata_val = 64'h0000_0000_0000_BEEF;
    exp_we_addr = 14'h0020; exp_re_addr = 14'h0030;
    d_evict_addr = 14'h0020; d_evict_data = 64'h1111; d_miss_addr = 14'h0030;
    d_dirty = 1; d_miss = 1;
    run_until_idle(60);
    d_dirty = 0;
    check_val("dirty_we_cycles", we_cyc - b_we, 4);
    check_val("dirty_wr_addr", wr_addr, 14'h0020);
    check_val("dirty_wr_data", wr_data, 64'h1111);
    check_val("dirty_we_addr", we_addr_err - b_wae, 0);
    check_val("dirty_re_addr", re_addr_err - b_rae, 0);
    check_val("dirty_overlap", overlap - b_ov, 0);
    check_val("dirty_dfill_data", dfill_data, 64'hBEEF);
    check_val("dirty_d_cnt", d_miss_cnt, 16'd2);

    // Simultaneous D and I misses
    snap();
    lat = 3; rdata_val = 64'hCAFE_0000_0000_0042;
    exp_re_addr = 14'h0000;
    d_miss_addr = 14'h0100; i_miss_addr = 14'h0003;
    d_miss = 1; i_miss = 1;
    run_until_idle(60);
    check_val("sim_dfill", dfill_n - b_df, 1);
    check_val("sim_ifill", ifill_n - b_if, 1);
    check_val("sim_d_first", (last_dfill_cyc < last_ifill_cyc), 1'b1);
    check_val("sim_gap", gap, 2);
    check_val("sim_d_cnt", d_miss_cnt, 16'd3);
    check_val("sim_i_cnt", i_miss_cnt, 16'd1);

    // I miss address changes while in flight
    snap();
    lat = 4; rdata_val = 64'h5555; exp_re_addr = 14'h0005;
    i_miss_addr = 14'h0005; i_miss = 1;
    repeat (2) @(negedge clk);
    i_miss_addr = 14'h0009;
    run_until_idle(40);
    check_val("iaddr_stable", re_addr_err - b_rae, 0);
    check_val("iaddr_ifill", ifill_n - b_if, 1);
    check_val("iaddr_data", ifill_data, 64'h5555);
    check_val("iaddr_i_cnt", i_miss_cnt, 16'd2);

    // D miss withdrawn mid-transaction still completes
    snap();
    lat = 4; rdata_val = 64'h4040; exp_re_addr = 14'h0040;
    d_miss_addr = 14'h0040; d_miss = 1;
    repeat (2) @(negedge clk);
    d_miss = 0;
    #1 check_val("drop_stall_busy", stall, 1'b1);
    run_until_idle(40);
    check_val("drop_dfill", dfill_n - b_df, 1);
    check_val("drop_d_cnt", d_miss_cnt, 16'd4);

    // Spurious u_rdy in IDLE is ignored
    snap();
    force_rdy = 1;
    rdata_val = 64'hDEAD;
    @(negedge clk);
    force_rdy = 0;
    repeat (2) @(negedge clk);
    check_val("idle_rdy_fills", (dfill_n - b_df) + (ifill_n - b_if), 0);
    check_val("idle_rdy_data", fill_data, 64'h4040);

    // Reset during D_FILL
    lat = 8; rdata_val = 64'h77; exp_re_addr = 14'h0050;
    d_miss_addr = 14'h0050; d_miss = 1;
    repeat (3) @(negedge clk);
    check_val("rstmid_in_fill", u_re, 1'b1);
    snap();
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_u_re", u_re, 1'b0);
    check_val("rstmid_fill_data", fill_data, 64'h0);
    check_val("rstmid_d_cnt", d_miss_cnt, 16'h0);
    repeat (2) @(negedge clk);
    check_val("rstmid_no_fill", dfill_n - b_df, 0);
    rst_n = 1'b1;
    snap();
    run_until_idle(60);
    check_val("rstmid_restart_fill", dfill_n - b_df, 1);
    check_val("rstmid_restart_data", dfill_data, 64'h77);
    check_val("rstmid_restart_cnt", d_miss_cnt, 16'd1);

    // Saturation from a preset of 16'hFFFE over three I fills
    check_val("sat_preset", s_i_cnt, 16'hFFFE);
    n = 0;
    i_miss2 = 1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (s_i_fill_we) n++;
    end
    i_miss2 = 0;
    repeat (3) @(negedge clk);
    check_val("sat_fills", n, 3);
    check_val("sat_i_cnt", s_i_cnt, 16'hFFFF);
    check_val("sat_d_cnt", s_d_cnt, 16'hFFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the line (block) address width, i.e. 16-bit word address bits [15:2].
REQ-002 Parameter LINE_W, default 64, SHALL set the cache line width (4 x 16-bit words).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_miss  input  1  instruction cache miss; held high until the line is filled.
REQ-006 i_miss_addr  input  ADDR_W  line address of the I-cache miss.
REQ-007 d_miss  input  1  data cache miss; held high until the line is filled.
REQ-008 d_miss_addr  input  ADDR_W  line address of the D-cache miss.
REQ-009 d_dirty  input  1  D-cache victim line is dirty; valid while d_miss is high.
REQ-010 d_evict_addr  input  ADDR_W  line address of the dirty victim.
REQ-011 d_evict_data  input  LINE_W  data of the dirty victim.
REQ-012 u_rdata  input  LINE_W  unified memory read data, valid when u_rdy is high.
REQ-013 u_rdy  input  1  unified memory one-cycle completion pulse.
REQ-014 u_re, u_we  output  1 each  unified memory read/write strobes.
REQ-015 u_addr  output  ADDR_W  unified memory line address.
REQ-016 u_wdata  output  LINE_W  unified memory write data.
REQ-017 i_fill_we, d_fill_we  output  1 each  one-cycle cache fill write enables.
REQ-018 fill_data  output  LINE_W  registered line for the active fill, shared by both caches.
REQ-019 stall  output  1  pipeline stall.
REQ-020 i_miss_cnt, d_miss_cnt  output  16 each  saturating serviced-miss counters.

Function
REQ-021 States SHALL be IDLE, D_WB, D_FILL, D_WRITE, I_FILL, I_WRITE.
REQ-022 IDLE SHALL go to D_WB if d_miss&d_dirty, else to D_FILL if d_miss, else to I_FILL if i_miss, else stay in IDLE; D-cache requests SHALL have priority over I-cache requests.
REQ-023 D_WB SHALL drive u_we=1, u_addr=d_evict_addr, u_wdata=d_evict_data, all stable until u_rdy, then go to D_FILL.
REQ-024 D_FILL and I_FILL SHALL drive u_re=1 with u_addr=d_miss_addr or i_miss_addr respectively, stable until u_rdy; on u_rdy they SHALL capture u_rdata into fill_data and go to D_WRITE or I_WRITE.
REQ-025 D_WRITE and I_WRITE SHALL assert d_fill_we or i_fill_we respectively for exactly one cycle, then return to IDLE.
REQ-026 The miss address SHALL be latched on leaving IDLE; later changes to miss inputs SHALL NOT alter an in-flight transaction.
REQ-027 u_re and u_we SHALL never be high together, and both SHALL be low in IDLE, D_WRITE and I_WRITE.
REQ-028 u_rdy SHALL be ignored in IDLE, D_WRITE and I_WRITE.
REQ-029 stall SHALL be combinational: (state!=IDLE) | i_miss | d_miss.
REQ-030 If a miss request drops mid-transaction, the memory access and fill write SHALL still complete.
REQ-031 Simultaneous i_miss and d_miss SHALL be serviced D first, then I, with no IDLE dead cycle beyond the single IDLE evaluation between them.
REQ-032 Each counter SHALL increment by 1 in the cycle its *_fill_we is high and SHALL saturate at 16'hFFFF.
REQ-033 fill_data SHALL hold its value outside capture cycles.

Reset
REQ-034 While rst_n is low: state=IDLE, fill_data=0, counters=0, and u_re, u_we, i_fill_we and d_fill_we low, effective immediately without waiting for a clock edge.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no fill write; after release, any still-asserted miss SHALL restart from IDLE.

Structure
REQ-036 The state enum, ADDR_W/LINE_W defaults and counter width SHALL reside in shared package mem_pkg.
REQ-037 The counters SHALL be two instances of sub-module sat_counter (16-bit, enable, async active-low reset).

Verification
REQ-038 Clean D miss: d_miss=1, d_dirty=0, addr=14'h0010, memory latency 4 cycles, u_rdata=64'hA5A5_0001_0002_0003 -> u_re for 4 cycles at 14'h0010, d_fill_we one pulse with that data, d_miss_cnt=1.
REQ-039 Dirty D miss: d_dirty=1, evict_addr=14'h0020, data 64'h1111 -> u_we at 14'h0020 until u_rdy, then u_re at the miss address, then d_fill_we; u_re and u_we never overlap.
REQ-040 Simultaneous i_miss (14'h0003) and d_miss (14'h0100) -> D serviced and filled first, I fill follows, stall high throughout, both counters = 1.
REQ-041 i_miss_addr changes 0x5 -> 0x9 during I_FILL -> u_addr remains 0x5 until u_rdy.
REQ-042 rst_n pulsed low in D_FILL -> outputs clear asynchronously, no d_fill_we; a held d_miss restarts after release.
REQ-043 Preload i_miss_cnt=16'hFFFE and service 3 I misses -> count reads 16'hFFFF and holds.
